// File: rtl/lab8_soc_final_keys_pio_if.sv
// Avalon-MM slave bus bundle for the lab8 key input PIO.
// The master drives address/strobes/data; the slave returns registered readdata.
interface lab8_soc_final_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab8_soc_final_keys_pio.sv
// Push-button input PIO: synchronizes and debounces the key inputs, latches
// selected edges into a write-1-to-clear capture register, and raises a maskable level irq.
module lab8_soc_final_keys_pio #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  lab8_soc_final_keys_pio_if.slave    avs,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  localparam int                  CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]    IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] deb_reg;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] edge_hit;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_reg;
  logic             wr_en;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= IDLE_VEC;
      s2_reg <= IDLE_VEC;
    end else begin
      s1_reg <= in_port;
      s2_reg <= s1_reg;
    end
  end

  // Per-bit stability counter; any sample back at the debounced level restarts it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             differs;

      assign differs      = (s2_reg[gi] != deb_reg[gi]);
      assign deb_next[gi] = (differs && (cnt_reg == CNT_MAX)) ? s2_reg[gi] : deb_reg[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (!differs || (cnt_reg == CNT_MAX)) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Edges come from the debounced update itself so capture lands with the data change.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = deb_next & ~deb_reg;
      1:       edge_hit = deb_reg & ~deb_next;
      default: edge_hit = deb_reg ^ deb_next;
    endcase
  end

  assign wr_en    = avs.chipselect && !avs.write_n;
  assign clr_vec  = (wr_en && (avs.address == 2'd3)) ? avs.writedata[WIDTH-1:0] : '0;
  assign cap_next = (cap_reg & ~clr_vec) | edge_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_reg  <= IDLE_VEC;
      cap_reg  <= '0;
      mask_reg <= '0;
    end else begin
      deb_reg <= deb_next;
      cap_reg <= cap_next;
      if (wr_en && (avs.address == 2'd2)) begin
        mask_reg <= avs.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      2'd0:    rd_mux[WIDTH-1:0] = deb_reg;
      2'd2:    rd_mux[WIDTH-1:0] = mask_reg;
      2'd3:    rd_mux[WIDTH-1:0] = cap_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else begin
      readdata_reg <= avs.chipselect ? rd_mux : 32'd0;
    end
  end

  assign avs.readdata = readdata_reg;
  assign irq          = |(cap_reg & mask_reg);

  // writedata bits above WIDTH have no destination.
  assign unused_wdata = ^avs.writedata;

endmodule

// File: tb/tb_lab8_soc_final_keys_pio.sv
// Scoreboard bench for the key PIO: reads push expected data into a queue and
// a monitor pops/compares one cycle later when readdata is presented.
module tb_lab8_soc_final_keys_pio;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = 4'hF;
  logic       irq;

  lab8_soc_final_keys_pio_if bus ();

  lab8_soc_final_keys_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rd_seen  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s = 0x%08h", nm, act);
    end
  endtask

  // Monitor: a read sampled at a rising edge is presented on readdata after that edge.
  always @(posedge clk) begin
    rd_seen <= reset_n && bus.chipselect && bus.write_n;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got 0x%08h, required no read", bus.readdata);
      end else begin
        e = exp_q.pop_front();
        chk(e.nm, bus.readdata, e.v);
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    bus.writedata  = 32'd0;
    exp_q.push_back('{v, nm});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Reset state and idle behaviour
    repeat (3) @(negedge clk);
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd(2'd0, 32'h0000_000F, "data_after_reset");
    rd(2'd1, 32'h0, "reserved_read");
    rd(2'd2, 32'h0, "mask_after_reset");
    rd(2'd3, 32'h0, "capture_after_reset");
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("irq_idle", {31'd0, irq}, 32'd0);
    end

    // Press bit0: DATA falls exactly at the 6th edge, seen by the read sampled at edge 7
    for (int i = 0; i < 7; i++) begin
      rd(2'd0, (i < 6) ? 32'h0000_000F : 32'h0000_000E, "data_press0");
      if (i == 0) in_port[0] = 1'b0;
    end
    rd(2'd3, 32'h1, "capture_press0");
    chk("irq_masked_off", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "reserved_after_write");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "capture_clear0");
    in_port[0] = 1'b1;
    idle_n(8);
    rd(2'd3, 32'h0, "no_rising_capture");
    rd(2'd0, 32'h0000_000F, "data_release0");

    // Mask enabled, press bit0 again: irq rises on the debounce edge
    wr(2'd2, 32'hFFFF_FFF1);
    idle();
    chk("irq_mask_no_capture", {31'd0, irq}, 32'd0);
    rd(2'd2, 32'h1, "mask_readback");
    idle();
    in_port[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("irq_before_deb", {31'd0, irq}, 32'd0);
    end
    idle();
    chk("irq_on_deb", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h0);
    idle();
    chk("irq_mask_off", {31'd0, irq}, 32'd0);
    rd(2'd3, 32'h1, "capture_retained");
    wr(2'd2, 32'h1);
    idle();
    chk("irq_mask_reenable", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "capture_clear_read");
    chk("irq_after_clear", {31'd0, irq}, 32'd0);
    idle();
    in_port[0] = 1'b1;
    idle_n(8);
    rd(2'd3, 32'h0, "no_capture_release");

    // Bounce on bit2: 3 low, 1 high, 3 low never reaches the stability count
    idle();
    in_port[2] = 1'b0;
    idle_n(2);
    idle();
    in_port[2] = 1'b1;
    idle();
    in_port[2] = 1'b0;
    idle_n(2);
    idle();
    in_port[2] = 1'b1;
    idle_n(8);
    rd(2'd0, 32'h0000_000F, "data_bounce");
    rd(2'd3, 32'h0, "capture_bounce");
    chk("irq_bounce", {31'd0, irq}, 32'd0);

    // Bit1 falling edge coincides with a clear of bit1: set wins
    idle();
    in_port[1] = 1'b0;
    idle_n(4);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h2, "capture_set_wins");
    chk("irq_bit1_unmasked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h3);
    idle();
    chk("irq_bit1_masked_in", {31'd0, irq}, 32'd1);
    idle();
    in_port[1] = 1'b1;
    idle_n(8);
    rd(2'd3, 32'h2, "capture_hold");

    // Reset mid-count on bit3, then the held-low key is debounced and captured
    idle();
    in_port[3] = 1'b0;
    rd(2'd3, 32'h2, "capture_before_reset");
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("readdata_reset_async", bus.readdata, 32'd0);
    chk("irq_reset_async", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, 32'h0, "mask_after_midreset");
    rd(2'd3, 32'h0, "capture_after_midreset");
    rd(2'd0, 32'h0000_000F, "data_bit3_pending");
    rd(2'd0, 32'h0000_000F, "data_bit3_pending");
    rd(2'd0, 32'h0000_000F, "data_bit3_pending");
    rd(2'd0, 32'h0000_0007, "data_bit3_fell");
    rd(2'd3, 32'h8, "capture_bit3");
    chk("irq_bit3_unmasked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h8);
    idle();
    chk("irq_bit3_masked_in", {31'd0, irq}, 32'd1);

    idle_n(2);
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
